// File: rtl/ram_seq_ctrl.sv
// RAM sequencer between the key filters and the segment-display driver.
// A write pulse fills the internal RAM with (addr + WR_SEED). A read pulse
// then steps through every address, holding each word for CNT_MAX+1 cycles,
// and wraps around forever.
// Optional feature: define RAM_SEQ_CTRL_PAUSE_EN so that rd_flag toggles
// pause/resume while reading. Otherwise rd_flag restarts the read at address 0.
`timescale 1ns / 1ps

module ram_seq_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WR_SEED = 0,
  parameter int unsigned CNT_MAX = 24_999_999
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_flag,
  input  logic              rd_flag,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_busy,
  output logic              rd_active
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam int unsigned CntW  = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StPause
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CntW-1:0]   cnt_q;
  logic              written_q;
  logic              wr_busy_q;
  logic              rd_active_q;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              dwell_done;

  // Address is resized to the word width before the seed offset is added.
  assign wr_data    = DATA_W'(wr_addr_q) + DATA_W'(WR_SEED);
  assign dwell_done = (cnt_q == CntW'(CNT_MAX));
  // Paused reads keep re-reading the frozen address, so rd_data stays put.
  assign rd_en      = (state_q == StRead) || (state_q == StPause);

  // Sequencer FSM with registered outputs; wr_flag outside WRITE always wins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      written_q   <= 1'b0;
      wr_busy_q   <= 1'b0;
      rd_active_q <= 1'b0;
    end else if (wr_flag && (state_q != StWrite)) begin
      state_q     <= StWrite;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      wr_busy_q   <= 1'b1;
      rd_active_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A read of never-written memory is silently refused.
          if (rd_flag && written_q) begin
            state_q     <= StRead;
            rd_addr_q   <= '0;
            cnt_q       <= '0;
            rd_active_q <= 1'b1;
          end
        end
        StWrite: begin
          wr_addr_q <= wr_addr_q + 1'b1;
          if (&wr_addr_q) begin
            state_q   <= StIdle;
            written_q <= 1'b1;
            wr_busy_q <= 1'b0;
          end
        end
        StRead: begin
          if (rd_flag) begin
`ifdef RAM_SEQ_CTRL_PAUSE_EN
            state_q <= StPause;
`else
            rd_addr_q <= '0;
            cnt_q     <= '0;
`endif
          end else if (dwell_done) begin
            cnt_q     <= '0;
            rd_addr_q <= rd_addr_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef RAM_SEQ_CTRL_PAUSE_EN
        StPause: begin
          // Counter untouched, so the remaining dwell resumes where it stopped.
          if (rd_flag) begin
            state_q <= StRead;
          end
        end
`endif
        default: begin
          state_q     <= StIdle;
          rd_active_q <= 1'b0;
          wr_busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Single write port; contents deliberately survive reset.
  always_ff @(posedge sys_clk) begin
    if (state_q == StWrite) begin
      mem[wr_addr_q] <= wr_data;
    end
  end

  // Registered read port; holds its last word outside READ/PAUSE.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr_q];
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_addr   = rd_addr_q;
  assign wr_busy   = wr_busy_q;
  assign rd_active = rd_active_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed bench for ram_seq_ctrl: two instances (WR_SEED 0 and 5) share stimulus.
`timescale 1ns / 1ps

module tb_ram_seq_ctrl;

  localparam int unsigned AddrW  = 8;
  localparam int unsigned DataW  = 8;
  localparam int unsigned CntMax = 99;

  logic             sys_clk   = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             wr_flag   = 1'b0;
  logic             rd_flag   = 1'b0;
  logic [DataW-1:0] rd_data, rd_data_s5;
  logic [AddrW-1:0] rd_addr, rd_addr_s5;
  logic             wr_busy, wr_busy_s5;
  logic             rd_active, rd_active_s5;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;

  always #5 sys_clk = ~sys_clk;

  ram_seq_ctrl #(
    .ADDR_W (AddrW),
    .DATA_W (DataW),
    .WR_SEED(0),
    .CNT_MAX(CntMax)
  ) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_flag  (wr_flag),
    .rd_flag  (rd_flag),
    .rd_data  (rd_data),
    .rd_addr  (rd_addr),
    .wr_busy  (wr_busy),
    .rd_active(rd_active)
  );

  ram_seq_ctrl #(
    .ADDR_W (AddrW),
    .DATA_W (DataW),
    .WR_SEED(5),
    .CNT_MAX(CntMax)
  ) u_dut_s5 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .wr_flag  (wr_flag),
    .rd_flag  (rd_flag),
    .rd_data  (rd_data_s5),
    .rd_addr  (rd_addr_s5),
    .wr_busy  (wr_busy_s5),
    .rd_active(rd_active_s5)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Counts observed busy cycles, starting from the current (busy) one.
  task automatic wait_write(output int n);
    n = 0;
    while (wr_busy === 1'b1 && n < 1000) begin
      n++;
      step();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values.
    step(3);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_wr_busy", wr_busy, 0);
    check_eq("rst_rd_active", rd_active, 0);
    sys_rst_n = 1'b1;
    step(2);

    // Read before any write is ignored.
    rd_flag = 1'b1;
    step();
    rd_flag = 1'b0;
    check_eq("unwritten_rd_active", rd_active, 0);
    check_eq("unwritten_rd_data", rd_data, 0);
    step(3);
    check_eq("unwritten_rd_active_later", rd_active, 0);

    // Write burst: busy for exactly 256 cycles.
    wr_flag = 1'b1;
    step();
    wr_flag = 1'b0;
    check_eq("wr_busy_rise", wr_busy, 1);
    check_eq("wr_rd_active", rd_active, 0);
    wait_write(cycles);
    check_eq("wr_busy_cycles", cycles, 256);
    check_eq("wr_busy_s5_end", wr_busy_s5, 0);
    for (int k = 0; k < 256; k++) begin
      check_eq("mem_seed0", u_dut.mem[k], k);
      check_eq("mem_seed5", u_dut_s5.mem[k], (k + 5) & 255);
    end
    check_eq("mem_seed5_last", u_dut_s5.mem[255], 4);

    // Full read pass with wrap back to address 0.
    rd_flag = 1'b1;
    step();
    rd_flag = 1'b0;
    check_eq("rd_active_rise", rd_active, 1);
    for (int a = 0; a <= 256; a++) begin
      check_eq("rd_addr_enter", rd_addr, a & 255);
      step();
      check_eq("rd_data", rd_data, a & 255);
      check_eq("rd_data_s5", rd_data_s5, (a + 5) & 255);
      step(CntMax - 1);
      check_eq("rd_addr_hold", rd_addr, a & 255);
      step();
    end

    // Simultaneous wr_flag and rd_flag at address 0x10: write wins.
    step(15 * (CntMax + 1));
    check_eq("rd_addr_0x10", rd_addr, 'h10);
    step(5);
    wr_flag = 1'b1;
    rd_flag = 1'b1;
    step();
    wr_flag = 1'b0;
    rd_flag = 1'b0;
    check_eq("abort_rd_active", rd_active, 0);
    check_eq("abort_wr_busy", wr_busy, 1);
    check_eq("abort_rd_addr", rd_addr, 0);
    check_eq("abort_rd_data_hold", rd_data, 'h10);
    wait_write(cycles);
    check_eq("abort_wr_cycles", cycles, 256);
    check_eq("abort_rd_data_idle", rd_data, 'h10);
    check_eq("abort_mem_s5_0", u_dut_s5.mem[0], 5);

    // rd_flag during READ at 0x20 after 40 dwell cycles.
    rd_flag = 1'b1;
    step();
    rd_flag = 1'b0;
    step(32 * (CntMax + 1));
    check_eq("rd_addr_0x20", rd_addr, 'h20);
    step(40);
    rd_flag = 1'b1;
    step();
    rd_flag = 1'b0;
`ifdef RAM_SEQ_CTRL_PAUSE_EN
    check_eq("pause_rd_active", rd_active, 1);
    check_eq("pause_rd_addr", rd_addr, 'h20);
    check_eq("pause_rd_data", rd_data, 'h20);
    step(1000);
    check_eq("pause_rd_addr_1000", rd_addr, 'h20);
    check_eq("pause_rd_data_1000", rd_data, 'h20);
    check_eq("pause_rd_active_1000", rd_active, 1);
    rd_flag = 1'b1;
    step();
    rd_flag = 1'b0;
    check_eq("resume_rd_addr", rd_addr, 'h20);
    step(59);
    check_eq("resume_rd_addr_59", rd_addr, 'h20);
    step();
    check_eq("resume_rd_addr_60", rd_addr, 'h21);
    step();
    check_eq("resume_rd_data", rd_data, 'h21);
`else
    check_eq("restart_rd_addr", rd_addr, 0);
    check_eq("restart_rd_active", rd_active, 1);
    check_eq("restart_rd_data_hold", rd_data, 'h20);
    step();
    check_eq("restart_rd_data", rd_data, 0);
    step(CntMax - 1);
    check_eq("restart_rd_addr_hold", rd_addr, 0);
    step();
    check_eq("restart_rd_addr_next", rd_addr, 1);
`endif

    // Asynchronous reset halfway through a write burst.
    wr_flag = 1'b1;
    step();
    wr_flag = 1'b0;
    step(127);
    check_eq("midwr_busy", wr_busy, 1);
    sys_rst_n = 1'b0;
    #1;
    check_eq("midrst_rd_data", rd_data, 0);
    check_eq("midrst_rd_addr", rd_addr, 0);
    check_eq("midrst_wr_busy", wr_busy, 0);
    check_eq("midrst_rd_active", rd_active, 0);
    check_eq("midrst_rd_data_s5", rd_data_s5, 0);
    check_eq("midrst_wr_busy_s5", wr_busy_s5, 0);
    step(2);
    sys_rst_n = 1'b1;
    rd_flag = 1'b1;
    step();
    rd_flag = 1'b0;
    check_eq("postrst_rd_ignored", rd_active, 0);
    step(5);
    check_eq("postrst_rd_ignored_later", rd_active, 0);
    check_eq("postrst_rd_data", rd_data_s5, 0);

    // A full write re-enables reads.
    wr_flag = 1'b1;
    step();
    wr_flag = 1'b0;
    wait_write(cycles);
    check_eq("rewr_cycles", cycles, 256);
    rd_flag = 1'b1;
    step();
    rd_flag = 1'b0;
    check_eq("reread_rd_active", rd_active, 1);
    check_eq("reread_rd_addr", rd_addr, 0);
    step();
    check_eq("reread_rd_data_s5", rd_data_s5, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_seq_ctrl.md
# ram_seq_ctrl

Parametrised RAM sequencer placed between the two key-filter outputs and the segment-display driver in the RAM demo top. A write pulse fills an internal single-port RAM with a generated pattern in one burst. A read pulse then steps through every address, holding each word on `rd_data` for a programmable dwell time, and wraps around continuously. This generalises the fixed 8-bit/256-word controller with configurable width, depth, seed and dwell, a write-abort path, a guard against reading unwritten memory, and optional pause/resume.

## Interface
- `ADDR_W`, 8, address width; depth DEPTH = 2^ADDR_W words.
- `DATA_W`, 8, RAM word width (1..32).
- `WR_SEED`, 0, pattern offset; word written at address a = (a + WR_SEED) mod 2^DATA_W.
- `CNT_MAX`, 24_999_999, dwell per read address minus one; dwell = CNT_MAX+1 cycles (≥1).
- `sys_clk` in 1 system clock, all logic rising-edge.
- `sys_rst_n` in 1 asynchronous, active-low reset.
- `wr_flag` in 1 one-cycle pulse from write key filter.
- `rd_flag` in 1 one-cycle pulse from read key filter.
- `rd_data` out DATA_W word currently displayed.
- `rd_addr` out ADDR_W address currently being read.
- `wr_busy` out 1 high while the write burst runs.
- `rd_active` out 1 high in READ (and PAUSE when enabled).

## Operation
- Reset: state IDLE; `rd_data`=0, `rd_addr`=0, `wr_busy`=0, `rd_active`=0, dwell counter=0, `written`=0. RAM contents are not reset.
- States: IDLE, WRITE, READ, PAUSE (PAUSE exists only with the macro).
- IDLE: `wr_flag` → WRITE. `rd_flag` → READ only if `written`=1; otherwise the pulse is ignored.
- WRITE: one word per cycle at wr_addr 0..DEPTH-1 with pattern data. After writing DEPTH-1: `written`←1 and → IDLE. All flags are ignored in WRITE, so a write cannot be restarted mid-burst.
- READ: `rd_addr` is held for CNT_MAX+1 cycles, then increments. After DEPTH-1 it wraps to 0. Reading never ends on its own.
- `wr_flag` in READ/PAUSE: aborts the read and goes to WRITE starting at address 0; `rd_addr`←0, counter←0.
- `rd_flag` and `wr_flag` high in the same cycle: `wr_flag` wins.
- Pattern arithmetic: the address is zero-extended (or truncated) to DATA_W, then WR_SEED is added modulo 2^DATA_W.
- RAM: inferred reg array, synchronous read, one write port.

## Timing
- `wr_flag` sampled at edge n: `wr_busy`=1 for cycles n+1..n+DEPTH. Address k is written at edge n+1+k. IDLE at n+DEPTH+1.
- `rd_flag` sampled at edge n (from IDLE): `rd_active`=1 and `rd_addr`=0 from n+1. `rd_data`=mem[0] from n+2. This one-cycle registered-read latency applies to every address change.
- `rd_addr` changes every CNT_MAX+1 cycles exactly. `rd_data` follows one cycle later.
- On leaving READ for WRITE, `rd_data` holds its last value. `rd_active` falls at the same edge `wr_busy` rises.
- Asynchronous reset mid-burst: outputs return to reset values immediately and `written`=0. A new write is required before any read is accepted.

## Configuration
- `RAM_SEQ_CTRL_PAUSE_EN` defined:
  - `rd_flag` in READ → PAUSE, with `rd_addr`, `rd_data` and the counter frozen.
  - `rd_flag` in PAUSE → READ, resuming with the remaining dwell.
  - `rd_active` stays 1 in PAUSE.
- Not defined: `rd_flag` in READ restarts the read at address 0 with counter 0 (`rd_data`=mem[0] two cycles later). PAUSE is not generated.

## Test plan
All cases use ADDR_W=8, DATA_W=8, WR_SEED=0, CNT_MAX=99.
- Reset, then `rd_flag` before any write → state stays IDLE, `rd_active`=0, `rd_data`=0.
- `wr_flag` → `wr_busy` high exactly 256 cycles. Backdoor check: mem[k]=k for all k. Repeat with WR_SEED=5: mem[255]=4.
- After the write, `rd_flag` → `rd_data`=0,1,2… changing every 100 cycles. After 0xFF, `rd_addr` wraps to 0 and `rd_data` returns to 0.
- During READ at address 0x10, `wr_flag` and `rd_flag` in the same cycle → the write wins: `rd_active`=0, `wr_busy`=1, and the burst restarts at address 0.
- With the macro, `rd_flag` at address 0x20 after 40 dwell cycles → output frozen for 1000 cycles. A second `rd_flag` → address 0x21 appears 60 cycles later. Without the macro, the same stimulus → `rd_addr`=0 on the next cycle.
- Assert `sys_rst_n` low halfway through a write burst → all outputs are 0 immediately. The next `rd_flag` is ignored until a full write completes.
